// File: rtl/fpga_tx_arbiter.sv
// Round-robin arbiter giving one of four requesters a single-byte slot on a shared transmitter.
// Optional per-byte watchdog is built when `FPGA_TX_TIMEOUT_EN is defined.
module fpga_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] reqData,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [7:0]  txData,
  output logic        txSent,
  input  logic        txBusy,
  input  logic        txFinish,
  output logic        arbBusy,
  output logic        timeoutErr
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_BUSY   = 3'd2,
    WAIT_FINISH = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t      state_r;
  logic [3:0]  grant_r;
  logic [3:0]  done_r;
  logic [7:0]  tx_data_r;
  logic        tx_sent_r;
  logic        arb_busy_r;
  logic        timeout_err_r;
  logic [1:0]  ptr_r;
  logic [1:0]  win_r;
  logic [1:0]  win_idx_s;
  logic        to_hit_s;

  // Round-robin pick: lowest offset above the last winner wins, offset 4 wraps to the last winner itself.
  always_comb begin
    win_idx_s = ptr_r;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr_r + 2'(i)]) begin
        win_idx_s = ptr_r + 2'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

`ifdef FPGA_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog counter: cleared while in START so it reads zero on WAIT_BUSY entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (state_r == START) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_FINISH)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign to_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0);
  assign to_hit_s = 1'b0;
`endif

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_r       <= 4'b0000;
      done_r        <= 4'b0000;
      tx_data_r     <= 8'h00;
      tx_sent_r     <= 1'b0;
      arb_busy_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      ptr_r         <= 2'd3;
      win_r         <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r        <= 4'b0000;
          timeout_err_r <= 1'b0;
          if ((|req) && !txBusy) begin
            grant_r    <= 4'b0001 << win_idx_s;
            tx_data_r  <= reqData[{win_idx_s, 3'b000} +: 8];
            win_r      <= win_idx_s;
            tx_sent_r  <= 1'b1;
            arb_busy_r <= 1'b1;
            state_r    <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          tx_sent_r <= 1'b0;
          state_r   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // A transmitter fast enough to finish without a visible busy phase goes straight to DONE.
          if (txFinish) begin
            done_r  <= grant_r;
            state_r <= DONE;
          end else if (to_hit_s) begin
            done_r        <= grant_r;
            timeout_err_r <= 1'b1;
            state_r       <= DONE;
          end else if (txBusy) begin
            state_r <= WAIT_FINISH;
          end else begin
            state_r <= WAIT_BUSY;
          end
        end
        WAIT_FINISH: begin
          if (txFinish) begin
            done_r  <= grant_r;
            state_r <= DONE;
          end else if (to_hit_s) begin
            done_r        <= grant_r;
            timeout_err_r <= 1'b1;
            state_r       <= DONE;
          end else begin
            state_r <= WAIT_FINISH;
          end
        end
        DONE: begin
          done_r        <= 4'b0000;
          timeout_err_r <= 1'b0;
          grant_r       <= 4'b0000;
          arb_busy_r    <= 1'b0;
          ptr_r         <= win_r;
          state_r       <= IDLE;
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= 4'b0000;
          done_r        <= 4'b0000;
          tx_sent_r     <= 1'b0;
          arb_busy_r    <= 1'b0;
          timeout_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign done       = done_r;
  assign txData     = tx_data_r;
  assign txSent     = tx_sent_r;
  assign arbBusy    = arb_busy_r;
  assign timeoutErr = timeout_err_r;

endmodule

// File: tb/tb_fpga_tx_arbiter.sv
// Directed bench for fpga_tx_arbiter: table of single-byte transactions plus hand-written
// sequences for streaming, busy blocking, mid-transaction reset and the watchdog.
module tb_fpga_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  txData;
  logic        txSent;
  logic        txBusy;
  logic        txFinish;
  logic        arbBusy;
  logic        timeoutErr;

  int total = 0;
  int bad   = 0;

  fpga_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .req(req), .reqData(reqData),
    .grant(grant), .done(done), .txData(txData), .txSent(txSent),
    .txBusy(txBusy), .txFinish(txFinish), .arbBusy(arbBusy), .timeoutErr(timeoutErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          busy_at;
    int          fin_at;
    logic [31:0] mid_data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_grant"}, 32'(grant), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_txdata"}, 32'(txData), 32'h0);
    chk({nm, "_txsent"}, 32'(txSent), 32'h0);
    chk({nm, "_arbbusy"}, 32'(arbBusy), 32'h0);
    chk({nm, "_toerr"}, 32'(timeoutErr), 32'h0);
  endtask

  // One transaction: busy high for cycles [busy_at, fin_at) after the txSent cycle, finish at fin_at.
  task automatic run_txn(input string nm, input vec_t v);
    int n_sent, n_done, n_err, bad_hold;
    logic [3:0] done_val;
    bit seen;
    n_sent = 0; n_done = 0; n_err = 0; bad_hold = 0; done_val = 4'b0000; seen = 1'b0;
    txBusy = 1'b0; txFinish = 1'b0;
    req = v.req; reqData = v.data;
    @(negedge clock);
    chk({nm, "_lat_grant"}, 32'(grant), 32'(v.exp_grant));
    chk({nm, "_lat_data"}, 32'(txData), 32'(v.exp_data));
    chk({nm, "_lat_sent"}, 32'(txSent), 32'h1);
    n_sent = int'(txSent);
    for (int c = 0; c < 60 && !seen; c++) begin
      txBusy   = (v.busy_at != 0) && (c >= v.busy_at) && (c < v.fin_at);
      txFinish = (c == v.fin_at);
      if (c == 1) begin
        req = 4'b0000; reqData = v.mid_data;
      end
      @(negedge clock);
      if (grant !== v.exp_grant || txData !== v.exp_data) bad_hold++;
      if (txSent) n_sent++;
      if (timeoutErr) n_err++;
      if (done != 4'b0000) begin
        n_done++; done_val = done; seen = 1'b1;
      end
    end
    txBusy = 1'b0; txFinish = 1'b0;
    @(negedge clock);
    chk({nm, "_hold"}, 32'(bad_hold), 32'h0);
    chk({nm, "_sent_once"}, 32'(n_sent), 32'h1);
    chk({nm, "_done_cnt"}, 32'(n_done), 32'h1);
    chk({nm, "_done_val"}, 32'(done_val), 32'(v.exp_grant));
    chk({nm, "_no_toerr"}, 32'(n_err), 32'h0);
    chk({nm, "_after_grant"}, 32'(grant), 32'h0);
    chk({nm, "_after_done"}, 32'(done), 32'h0);
    chk({nm, "_after_busy"}, 32'(arbBusy), 32'h0);
  endtask

  initial begin
    logic [3:0] order[5];
    logic [3:0] exp_order[5];
    logic [3:0] done_at;
    int ng, idle_run, max_idle, hold_bad, n_pulse, first, err_at;
    bit fin_next;
    vec_t v;

    // Pointer walks 3 ->0 ->1 ->0 ->2 ->3 ->0 ->3 across the table.
    vecs[0] = '{4'b0001, 32'h0000_00A5, 2, 3, 32'h0000_00A5, 4'b0001, 8'hA5};
    vecs[1] = '{4'b1111, 32'h4433_2211, 0, 1, 32'h4433_2211, 4'b0010, 8'h22};
    vecs[2] = '{4'b0011, 32'h4433_2211, 0, 1, 32'h4433_2211, 4'b0001, 8'h11};
    vecs[3] = '{4'b0100, 32'h00CC_0000, 1, 4, 32'hFFFF_FFFF, 4'b0100, 8'hCC};
    vecs[4] = '{4'b1100, 32'h9A00_0000, 1, 2, 32'h9A00_0000, 4'b1000, 8'h9A};
    vecs[5] = '{4'b1001, 32'h1000_005E, 0, 2, 32'h1000_005E, 4'b0001, 8'h5E};
    vecs[6] = '{4'b1000, 32'h7F00_0000, 2, 5, 32'h7F00_0000, 4'b1000, 8'h7F};

    reset = 1'b1; req = 4'b0000; reqData = 32'h0; txBusy = 1'b0; txFinish = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_idle_outputs("post_rst");

    for (int i = 0; i < 7; i++) run_txn($sformatf("v%0d", i), vecs[i]);

    // Held request from all four: grants must rotate with at most one idle cycle between bytes.
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    ng = 0; idle_run = 0; max_idle = 0; fin_next = 1'b0;
    req = 4'b1111; reqData = 32'h4433_2211;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      txFinish = fin_next;
      fin_next = txSent;
      if (txSent) begin
        if (ng < 5) order[ng] = grant;
        ng++;
        if (ng == 5) req = 4'b0000;
      end
      if (ng >= 1 && ng <= 4) begin
        if (!arbBusy) idle_run++; else idle_run = 0;
        if (idle_run > max_idle) max_idle = idle_run;
      end
      if (ng >= 5 && !arbBusy && !fin_next) break;
    end
    txFinish = 1'b0;
    chk("rr_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    chk("rr_gap", 32'(max_idle <= 1), 32'h1);

    // Transmitter busy at request time blocks arbitration until it drops.
    txBusy = 1'b1; req = 4'b0010; reqData = 32'h0000_3C00; hold_bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (grant != 4'b0000 || txSent) hold_bad++;
    end
    chk("busy_block", 32'(hold_bad), 32'h0);
    v = '{4'b0010, 32'h0000_3C00, 0, 1, 32'h0000_3C00, 4'b0010, 8'h3C};
    run_txn("busy_release", v);

    // Reset in WAIT_FINISH: outputs clear at once, no done, pointer returns to requester 0.
    req = 4'b0001; reqData = 32'h0000_0077;
    @(negedge clock);
    chk("rstmid_grant", 32'(grant), 32'h1);
    txBusy = 1'b1; req = 4'b0000;
    n_pulse = 0;
    repeat (2) begin
      @(negedge clock);
      if (done != 4'b0000) n_pulse++;
    end
    reset = 1'b1;
    @(negedge clock);
    chk_idle_outputs("rstmid");
    reset = 1'b0; txBusy = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done != 4'b0000) n_pulse++;
    end
    chk("rstmid_no_done", 32'(n_pulse), 32'h0);
    v = '{4'b1001, 32'h8800_0066, 0, 1, 32'h8800_0066, 4'b0001, 8'h66};
    run_txn("rstmid_next", v);

    // Silent transmitter: watchdog forces DONE, or without it the arbiter waits indefinitely.
    req = 4'b0001; reqData = 32'h0000_0042; txBusy = 1'b0; txFinish = 1'b0;
    @(negedge clock);
    chk("to_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    first = 0; err_at = 0; done_at = 4'b0000;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(negedge clock);
      if (done != 4'b0000) begin
        first = c; done_at = done; err_at = int'(timeoutErr);
      end
    end
`ifdef FPGA_TX_TIMEOUT_EN
    chk("to_cycle", 32'(first), 32'd17);
    chk("to_done", 32'(done_at), 32'h1);
    chk("to_err", 32'(err_at), 32'h1);
    @(negedge clock);
    chk("to_after_done", 32'(done), 32'h0);
    chk("to_after_err", 32'(timeoutErr), 32'h0);
    chk("to_after_busy", 32'(arbBusy), 32'h0);
`else
    chk("to_none", 32'(first), 32'h0);
    chk("to_stuck", 32'(arbBusy), 32'h1);
    chk("to_err_tied", 32'(timeoutErr), 32'h0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("to_recover", 32'(arbBusy), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpga_tx_arbiter.md
FPGA_TX_ARBITER -- requirements
Module: fpga_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles to wait for txBusy/txFinish per byte; used only with FPGA_TX_TIMEOUT_EN.
REQ-002 clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester byte-send request, level, bit i = requester i.
REQ-005 reqData  input  32  packed bytes; requester i uses reqData[8i+7:8i].
REQ-006 grant  output  4  one-hot ownership of the transmitter, held for the whole transaction.
REQ-007 done  output  4  one-cycle pulse on bit i when requester i's byte is finished.
REQ-008 txData  output  8  byte to transmitter dataIn; stable while any grant bit is set.
REQ-009 txSent  output  1  one-cycle start strobe to transmitter sent input.
REQ-010 txBusy  input  1  transmitter busy status.
REQ-011 txFinish  input  1  transmitter finish status.
REQ-012 arbBusy  output  1  high in every state except IDLE.
REQ-013 timeoutErr  output  1  one-cycle pulse coincident with done on a timed-out transaction.

Function
REQ-014 States SHALL be IDLE, START, WAIT_BUSY, WAIT_FINISH, DONE.
REQ-015 IDLE: if any req bit is high and txBusy is low, the block SHALL select a winner, load grant and txData at that edge, and go to START.
REQ-016 IDLE with txBusy high SHALL hold IDLE, ignoring req.
REQ-017 Winner selection SHALL be round-robin: search from requester (last+1) mod 4 upward with wrap; pointer after reset = requester 0 first.
REQ-018 START: txSent = 1 for exactly this one cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: txBusy high -> WAIT_FINISH; txFinish high (fast transmitter) -> DONE directly; otherwise stay.
REQ-020 WAIT_FINISH: txFinish high -> DONE; otherwise stay.
REQ-021 DONE: done[winner] = 1 for one cycle; grant clears at the end of this cycle; pointer = winner; next state IDLE.
REQ-022 Latency: req sampled at edge k -> grant/txData valid after edge k, txSent high in cycle k+1; minimum per-byte period 4 cycles.
REQ-023 reqData and req changes after grant SHALL be ignored until DONE; a dropped req does not abort the transaction.
REQ-024 A requester still asserting req in the IDLE cycle after its done SHALL be treated as a new request and arbitrated normally (no back-to-back priority).
REQ-025 txSent SHALL never assert outside START; grant SHALL never have more than one bit set.

Reset
REQ-026 On reset: state IDLE, grant = 0, done = 0, txData = 0, txSent = 0, arbBusy = 0, timeoutErr = 0, pointer = 3 (so requester 0 wins first), timeout counter = 0.
REQ-027 Reset asserted mid-transaction SHALL take effect at the next edge regardless of state; no done pulse is produced for the aborted byte.

Configuration
REQ-028 Macro FPGA_TX_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_BUSY, increment each cycle in WAIT_BUSY/WAIT_FINISH, and on reaching TIMEOUT_CYCLES force DONE with timeoutErr pulsed alongside done.
REQ-029 Macro not defined: no counter is built, WAIT states wait indefinitely, timeoutErr is tied 0.

Verification
REQ-030 Reset, req=4'b0001, reqData[7:0]=8'hA5, txBusy rises 2 cycles after txSent, txFinish 1 cycle later -> grant=0001, txData=A5, one txSent pulse, done=0001 one cycle.
REQ-031 req=4'b1111 held, transmitter model completes each byte -> grant order 0001,0010,0100,1000,0001; no gap longer than 1 IDLE cycle.
REQ-032 txBusy held high from reset, req=4'b0010 -> no grant, no txSent until txBusy falls; then normal grant to requester 1.
REQ-033 Grant to requester 2, then reqData[23:16] changed and req[2] dropped mid-transaction -> txData unchanged, done=0100 still pulses.
REQ-034 Reset asserted during WAIT_FINISH -> all outputs 0 next cycle, no done pulse; next req=4'b0001 served first.
REQ-035 FPGA_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, txBusy/txFinish never asserted -> done and timeoutErr pulse together 16 cycles after WAIT_BUSY entry; without the macro the arbiter remains in WAIT_BUSY.
